// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB (A) vs long-latency unit (B),
// one registered write per cycle, plus a busy scoreboard for outstanding long-latency writes.
module rf_wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,
    output logic [31:0] busy
);

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0]  r_starve_cnt;
    logic        r_rf_we;
    logic [4:0]  r_rf_rd;
    logic [31:0] r_rf_data;
    logic [31:0] r_busy;

    logic        w_b_force;
    logic        w_a_xfer;
    logic        w_b_xfer;
    logic [4:0]  w_wr_rd;
    logic [31:0] w_wr_data;
    logic [31:0] w_busy_next;
    logic [3:0]  w_starve_next;

    assign w_b_force = (r_starve_cnt >= LP_STARVE_MAX);
    assign a_ready   = a_valid && !w_b_force;
    assign b_ready   = b_valid && (!a_valid || w_b_force);
    assign w_a_xfer  = a_valid && a_ready;
    assign w_b_xfer  = b_valid && b_ready;

    assign w_wr_rd   = w_b_xfer ? b_rd   : a_rd;
    assign w_wr_data = w_b_xfer ? b_data : a_data;

    always_comb begin
        w_starve_next = r_starve_cnt;
        if (!b_valid || b_ready) begin
            w_starve_next = 4'd0;
        end else if (r_starve_cnt != 4'hF) begin
            w_starve_next = r_starve_cnt + 4'd1;
        end
    end

    // Set is applied after clear so a fresh issue supersedes a retiring write.
    always_comb begin
        w_busy_next = r_busy;
        if (w_b_xfer) begin
            w_busy_next[b_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            w_busy_next[issue_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= 4'd0;
            r_rf_we      <= 1'b0;
            r_rf_rd      <= 5'd0;
            r_rf_data    <= 32'd0;
            r_busy       <= 32'd0;
        end else begin
            r_starve_cnt <= w_starve_next;
            r_busy       <= w_busy_next;
            r_rf_we      <= 1'b0;
            if (w_a_xfer || w_b_xfer) begin
                r_rf_we   <= (w_wr_rd != 5'd0);
                r_rf_rd   <= w_wr_rd;
                r_rf_data <= w_wr_data;
            end
        end
    end

    assign rf_we   = r_rf_we;
    assign rf_rd   = r_rf_rd;
    assign rf_data = r_rf_data;
    assign busy    = r_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: grants and busy checked inline, register-file
// writes checked by a monitor against a queue of expected writes.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0;
    logic [4:0]  a_rd = '0;
    logic [31:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_rd = '0;
    logic [31:0] b_data = '0;
    logic        b_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [31:0] busy;

    rf_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every expected write must appear exactly in its due cycle; nothing else may write.
    always @(negedge clk) begin
        if (reset_n) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                wr_t e;
                e = q.pop_front();
                chk("mon_rf_we",   {31'd0, rf_we}, 32'd1);
                chk("mon_rf_rd",   {27'd0, rf_rd}, {27'd0, e.rd});
                chk("mon_rf_data", rf_data, e.data);
            end else if (rf_we) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected_write: got rf_we=1 rf_rd=%0d rf_data=0x%08h expected rf_we=0 (cycle %0d)",
                         rf_rd, rf_data, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                         input logic iv, input logic [4:0] ird);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        issue_valid = iv; issue_rd = ird;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Check the hand-computed grant for the currently driven inputs and queue the resulting write.
    task automatic grant(input string name, input logic ea, input logic eb);
        #1;
        chk({name, "_a_ready"}, {31'd0, a_ready}, {31'd0, ea});
        chk({name, "_b_ready"}, {31'd0, b_ready}, {31'd0, eb});
        if (ea && a_rd != 5'd0) q.push_back('{due: cyc + 1, rd: a_rd, data: a_data});
        if (eb && b_rd != 5'd0) q.push_back('{due: cyc + 1, rd: b_rd, data: b_data});
    endtask

    initial begin
        // Reset state
        idle();
        #1;
        chk("rst_rf_we",   {31'd0, rf_we}, 32'd0);
        chk("rst_rf_rd",   {27'd0, rf_rd}, 32'd0);
        chk("rst_rf_data", rf_data, 32'd0);
        chk("rst_busy",    busy, 32'd0);
        tick(); tick();
        reset_n = 1'b1;

        // Single A write, then idle
        tick();
        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        grant("a_only", 1, 0);
        tick();
        idle();
        grant("idle1", 0, 0);
        tick();
        chk("idle_rf_we",   {31'd0, rf_we}, 32'd0);
        chk("idle_rf_rd_hold", {27'd0, rf_rd}, 32'd5);

        // Contention: A wins cycles 0-3, B forced on cycle 4, A again on cycle 5
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'd1, 32'h100 + i, 1, 5'd2, 32'hB0B0B0B0, 0, 0);
            grant($sformatf("cont%0d", i), 1, 0);
            tick();
        end
        drive(1, 5'd1, 32'h104, 1, 5'd2, 32'hB0B0B0B0, 0, 0);
        grant("cont4", 0, 1);
        tick();
        drive(1, 5'd1, 32'h104, 1, 5'd3, 32'hC0C0C0C0, 0, 0);
        grant("cont5", 1, 0);
        tick();
        idle();
        tick();

        // Issue rd=9, B retires rd=9 four cycles later
        drive(0, 0, 0, 0, 0, 0, 1, 5'd9);
        grant("issue9", 0, 0);
        tick();
        idle();
        chk("busy9_set", busy, 32'h0000_0200);
        tick(); tick(); tick();
        drive(0, 0, 0, 1, 5'd9, 32'h0000_0099, 0, 0);
        grant("b9", 0, 1);
        tick();
        idle();
        chk("busy9_clr", busy, 32'h0);
        tick();

        // Same-edge issue and retire of rd=9: set wins
        drive(0, 0, 0, 0, 0, 0, 1, 5'd9);
        grant("issue9b", 0, 0);
        tick();
        drive(0, 0, 0, 1, 5'd9, 32'h0000_0077, 1, 5'd9);
        grant("b9_same", 0, 1);
        tick();
        idle();
        chk("busy9_same_edge", busy, 32'h0000_0200);
        drive(0, 0, 0, 1, 5'd9, 32'h0000_0078, 0, 0);
        grant("b9_retire", 0, 1);
        tick();
        idle();
        chk("busy9_retired", busy, 32'h0);
        tick();

        // r0 write and issue: accepted, no write, no busy
        drive(1, 5'd0, 32'h1234_5678, 0, 0, 0, 1, 5'd0);
        grant("a_r0", 1, 0);
        tick();
        idle();
        chk("r0_rf_we", {31'd0, rf_we}, 32'd0);
        chk("r0_busy",  busy, 32'h0);
        tick();

        // Reset mid-stream with B starved (count 3) and busy[9] set
        drive(0, 0, 0, 0, 0, 0, 1, 5'd9);
        grant("issue9c", 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd4, 32'h400 + i, 1, 5'd6, 32'h6666_6666, 0, 0);
            grant($sformatf("pre_rst%0d", i), 1, 0);
            tick();
        end
        chk("pre_rst_busy", busy, 32'h0000_0200);
        drive(1, 5'd4, 32'h403, 1, 5'd6, 32'h6666_6666, 0, 0);
        q.delete();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rf_we",   {31'd0, rf_we}, 32'd0);
        chk("mid_rst_rf_rd",   {27'd0, rf_rd}, 32'd0);
        chk("mid_rst_rf_data", rf_data, 32'd0);
        chk("mid_rst_busy",    busy, 32'd0);
        tick();
        reset_n = 1'b1;
        grant("post_rst", 1, 0);
        tick();
        idle();
        tick(); tick();

        chk("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
